dft64_sample_loader: RTL and testbench
======================================

DFT64_SAMPLE_LOADER -- requirements
Module: dft64_sample_loader

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of one signed input sample.
REQ-002 SHALL have parameter N_POINTS, default 64, frame length; only 64 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-006 SHALL have port in_data, input, SAMPLE_W, upstream sample, frame order index 0 first.
REQ-007 SHALL have port in_ready, output, 1, loader accepts in_data this cycle.
REQ-008 SHALL have port calculate, output, 1, one-cycle start pulse to the downstream dft64.
REQ-009 SHALL have port done, input, 1, dft64 completion for the launched frame.
REQ-010 SHALL have port samples, output, N_POINTS*SAMPLE_W, frame under computation, sample k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-011 SHALL have port busy, output, 1, a frame is launched and done not yet seen.
REQ-012 SHALL have port frame_count, output, 8, count of launched frames, wraps 255->0.

Function
REQ-013 SHALL accept a sample only on a cycle where in_valid and in_ready are both high, writing it at the current write index.
REQ-014 SHALL advance the write index 0..63 by one per accepted sample and wrap 63->0 on the 64th.
REQ-015 SHALL use states FILL, LAUNCH, WAIT_DONE: FILL->LAUNCH on the 64th accept; LAUNCH->WAIT_DONE unconditionally; WAIT_DONE->FILL on done high.
REQ-016 SHALL drive calculate high for exactly the one cycle in LAUNCH, i.e. one cycle after the 64th accept.
REQ-017 SHALL hold samples constant from the LAUNCH cycle until the cycle done is sampled high.
REQ-018 SHALL drive in_ready high only in FILL (single-buffer build).
REQ-019 SHALL assert busy from LAUNCH through the cycle done is sampled, and deassert it the next cycle.
REQ-020 SHALL ignore done in FILL and in LAUNCH; done in LAUNCH does not end the frame.
REQ-021 SHALL increment frame_count on every calculate pulse.
REQ-022 SHALL store samples unmodified; no arithmetic or width conversion.

Reset
REQ-023 SHALL on reset_n low immediately force state FILL, write index 0, calculate 0, busy 0, frame_count 0, in_ready 0, and all sample storage 0.
REQ-024 SHALL raise in_ready on the first clock edge after reset_n deasserts.
REQ-025 SHALL discard any partially filled or in-flight frame on reset; no calculate follows a mid-frame reset.

Configuration
REQ-026 SHALL compile ping-pong buffering when macro DFT64_LOADER_DOUBLE_BUF_EN is defined; otherwise single buffer per REQ-018.
REQ-027 With DFT64_LOADER_DOUBLE_BUF_EN defined, it SHALL keep two banks; after a launch, in_ready stays high and filling continues into the other bank.
REQ-028 With DFT64_LOADER_DOUBLE_BUF_EN defined, if the fill bank completes while busy, it SHALL hold in_ready low until done, then pulse calculate on the cycle after done with samples switched to that bank.
REQ-029 With DFT64_LOADER_DOUBLE_BUF_EN defined, if done and the 64th accept coincide, it SHALL launch the new bank on the next cycle with no lost sample.

Structure
REQ-030 SHALL take N_POINTS, IDX_W (6), and the state enum from shared package dft64_pkg.
REQ-031 SHALL instantiate each bank as sub-module dft64_sample_bank (64 x SAMPLE_W registers, write-enable plus index, flat readout).

Verification
REQ-032 Bench SHALL drive 64 continuous samples 0..63 -> calculate high exactly one cycle after the 64th accept, samples[k]=k, in_ready 0, frame_count 1.
REQ-033 Bench SHALL hold done low for 200 cycles then pulse it -> samples stable throughout, busy 0 and in_ready 1 on the next cycle.
REQ-034 Bench SHALL toggle in_valid randomly over 64 accepts -> exactly 64 stored in order and one calculate pulse.
REQ-035 Bench SHALL assert reset_n low after 30 accepts -> index 0 and no calculate; next 64 samples 100..163 give samples[0]=100.
REQ-036 Bench SHALL pulse done while in FILL -> no state change, calculate stays 0.
REQ-037 Bench SHALL with DFT64_LOADER_DOUBLE_BUF_EN stream 128 samples with done delayed -> in_ready low after 128 accepts until done, second calculate the cycle after done, samples[0]=64.

Source files
------------

// File: rtl/dft64_pkg.sv
// Shared constants and FSM state type for the dft64 sample loader family.
package dft64_pkg;

  localparam int N_POINTS = 64;
  localparam int IDX_W    = 6;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/dft64_sample_bank.sv
// One 64-entry sample store: indexed single-port write, whole frame read out flat.
module dft64_sample_bank
  import dft64_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [SAMPLE_W-1:0]          wdata,
  output logic [N_POINTS*SAMPLE_W-1:0] rdata
);

  logic [N_POINTS-1:0][SAMPLE_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  // Packed element k lands at bits [k*SAMPLE_W +: SAMPLE_W].
  assign rdata = mem_q;

endmodule

// File: rtl/dft64_sample_loader.sv
// Collects 64-sample frames and launches them into a dft64 core.
// Define DFT64_LOADER_DOUBLE_BUF_EN for ping-pong banks (fill while the core is busy).
module dft64_sample_loader #(
  parameter int SAMPLE_W = 16,
  parameter int N_POINTS = dft64_pkg::N_POINTS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [SAMPLE_W-1:0]          in_data,
  output logic                         in_ready,
  output logic                         calculate,
  input  logic                         done,
  output logic [N_POINTS*SAMPLE_W-1:0] samples,
  output logic                         busy,
  output logic [7:0]                   frame_count
);
  import dft64_pkg::*;

`ifdef DFT64_LOADER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             calc_q, calc_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             accept, last, launch;

  logic [NB-1:0]                         bank_we;
  logic [NB-1:0][N_POINTS*SAMPLE_W-1:0]  bank_rd;

  assign accept = in_valid && in_ready_q;
  assign last   = accept && (wr_idx_q == IDX_W'(N_POINTS - 1));

  // pend marks a completed fill bank still waiting for the core to free up.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = accept ? wr_idx_q + IDX_W'(1) : wr_idx_q;
    pend_d   = pend_q;
    launch   = 1'b0;
    case (state_q)
      FILL:      launch = last;
      LAUNCH: begin
        state_d = WAIT_DONE;
        if (last) pend_d = 1'b1;
      end
      WAIT_DONE: begin
        if (done) begin
          if (pend_q || last) launch  = 1'b1;
          else                state_d = FILL;
        end else if (last) begin
          pend_d = 1'b1;
        end
      end
      default:   state_d = FILL;
    endcase
    if (launch) begin
      state_d = LAUNCH;
      pend_d  = 1'b0;
    end
    calc_d      = launch;
    busy_d      = (state_d != FILL);
    frame_cnt_d = frame_cnt_q + 8'(launch);
`ifdef DFT64_LOADER_DOUBLE_BUF_EN
    in_ready_d  = !pend_d;
`else
    in_ready_d  = (state_d == FILL);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      calc_q      <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      in_ready_q  <= in_ready_d;
      calc_q      <= calc_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef DFT64_LOADER_DOUBLE_BUF_EN
  logic fill_q, fill_d;
  logic disp_q, disp_d;

  // On launch the just-filled bank goes on display and filling moves to the other.
  always_comb begin
    fill_d = fill_q;
    disp_d = disp_q;
    if (launch) begin
      disp_d = fill_q;
      fill_d = ~fill_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q <= 1'b0;
      disp_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      disp_q <= disp_d;
    end
  end

  assign bank_we = {accept && fill_q, accept && !fill_q};
  assign samples = bank_rd[disp_q];
`else
  assign bank_we = accept;
  assign samples = bank_rd[0];
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    dft64_sample_bank #(.SAMPLE_W(SAMPLE_W)) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (bank_we[b]),
      .idx     (wr_idx_q),
      .wdata   (in_data),
      .rdata   (bank_rd[b])
    );
  end

  assign in_ready    = in_ready_q;
  assign calculate   = calc_q;
  assign busy        = busy_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_dft64_sample_loader.sv
// Randomized bench for dft64_sample_loader against a frame-level reference model.
module tb_dft64_sample_loader;
  localparam int SW = 16;
  localparam int NP = 64;
`ifdef DFT64_LOADER_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n, in_valid, done;
  logic [SW-1:0]  in_data;
  logic           in_ready, calculate, busy;
  logic [NP*SW-1:0] samples;
  logic [7:0]     frame_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dft64_sample_loader #(.SAMPLE_W(SW), .N_POINTS(NP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .calculate   (calculate),
    .done        (done),
    .samples     (samples),
    .busy        (busy),
    .frame_count (frame_count)
  );

  // Model: samples accumulate into a frame; a finished frame is handed to the
  // core as soon as the core is free, and the core is freed by done.
  logic [SW-1:0] mem[NP], cur[NP], comp[NP], shown[NP];
  int            cnt, accepts;
  bit            comp_v, launched, e_ready, e_calc, e_busy;
  logic [7:0]    e_fc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] exp_s(int i);
    return (DBL && launched) ? shown[i] : mem[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mem[i] = '0; cur[i] = '0; comp[i] = '0; shown[i] = '0;
    end
    cnt = 0; comp_v = 0; launched = 0;
    e_ready = 0; e_calc = 0; e_busy = 0; e_fc = '0;
  endtask

  task automatic model_edge(bit v, logic [SW-1:0] d, bit dn);
    if (v && e_ready) begin
      mem[cnt] = d;
      cur[cnt] = d;
      cnt++;
      accepts++;
      if (cnt == NP) begin
        comp   = cur;
        comp_v = 1;
        cnt    = 0;
      end
    end
    if (e_busy && !e_calc && dn) e_busy = 0;
    e_calc = 0;
    if (!e_busy && comp_v) begin
      shown    = comp;
      comp_v   = 0;
      e_busy   = 1;
      e_calc   = 1;
      e_fc     = e_fc + 8'd1;
      launched = 1;
    end
    e_ready = DBL ? !comp_v : !e_busy;
  endtask

  task automatic compare_all(string ph);
    int k = 0;
    chk({ph, ":in_ready"},    64'(in_ready),    64'(e_ready));
    chk({ph, ":calculate"},   64'(calculate),   64'(e_calc));
    chk({ph, ":busy"},        64'(busy),        64'(e_busy));
    chk({ph, ":frame_count"}, 64'(frame_count), 64'(e_fc));
    for (int i = 0; i < NP; i++) begin
      if (samples[i*SW +: SW] !== exp_s(i)) begin
        k = i;
        break;
      end
    end
    chk($sformatf("%s:samples[%0d]", ph, k), 64'(samples[k*SW +: SW]), 64'(exp_s(k)));
  endtask

  task automatic cyc(bit v, logic [SW-1:0] d, bit dn, string ph);
    in_valid = v;
    in_data  = d;
    done     = dn;
    @(posedge clk);
    model_edge(v, d, dn);
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    done     = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Run cycles until n more samples are accepted (in-order data from base, or random).
  task automatic feed(int n, bit rnd_v, bit rnd_d, int base, string ph);
    int start = accepts;
    int guard = 0;
    while (accepts - start < n) begin
      bit            v = rnd_v ? bit'($urandom_range(0, 1)) : 1'b1;
      logic [SW-1:0] d = rnd_d ? SW'($urandom) : SW'(base + accepts - start);
      cyc(v, d, 1'b0, ph);
      guard++;
      if (guard > 4000) begin
        chk({ph, ":accept_timeout"}, 64'(accepts - start), 64'(n));
        break;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    done     = 1'b0;
    accepts  = 0;
    #2;
    do_reset();

    // Continuous frame 0..63.
    cyc(1'b0, '0, 1'b0, "idle");
    feed(NP, 1'b0, 1'b0, 0, "r032");
    chk("r032_calc", 64'(calculate), 64'd1);
    chk("r032_s0",   64'(samples[0 +: SW]), 64'd0);
    chk("r032_s63",  64'(samples[63*SW +: SW]), 64'd63);
    chk("r032_fc",   64'(frame_count), 64'd1);
`ifndef DFT64_LOADER_DOUBLE_BUF_EN
    chk("r032_ready", 64'(in_ready), 64'd0);
`endif

    // Long wait for done with upstream still offering data.
    repeat (200) cyc(bit'($urandom_range(0, 1)), SW'($urandom), 1'b0, "r033");
    cyc(1'b0, '0, 1'b1, "r033_done");
`ifndef DFT64_LOADER_DOUBLE_BUF_EN
    chk("r033_busy",  64'(busy), 64'd0);
    chk("r033_ready", 64'(in_ready), 64'd1);
    chk("r033_s5",    64'(samples[5*SW +: SW]), 64'd5);
`else
    chk("r033_calc",  64'(calculate), 64'd1);
`endif

    // Stray done pulses while idle.
    repeat (5) cyc(1'b0, '0, 1'b1, "r036");
`ifndef DFT64_LOADER_DOUBLE_BUF_EN
    chk("r036_calc", 64'(calculate), 64'd0);
    chk("r036_busy", 64'(busy), 64'd0);
`endif

    // Gappy valid, random data.
    feed(NP, 1'b1, 1'b1, 0, "r034");
`ifndef DFT64_LOADER_DOUBLE_BUF_EN
    chk("r034_calc", 64'(calculate), 64'd1);
    chk("r034_fc",   64'(frame_count), 64'd2);
`endif
    // done during the launch cycle must not end the frame.
    cyc(1'b0, '0, 1'b1, "launch_done");
`ifndef DFT64_LOADER_DOUBLE_BUF_EN
    chk("launch_done_busy", 64'(busy), 64'd1);
`endif
    cyc(1'b0, '0, 1'b1, "wait_done");

    // Mid-frame reset discards the partial frame.
    do_reset();
    cyc(1'b0, '0, 1'b0, "idle");
    feed(30, 1'b0, 1'b1, 0, "r035_pre");
    do_reset();
    repeat (70) cyc(1'b0, '0, 1'b0, "r035_quiet");
    feed(NP, 1'b0, 1'b0, 100, "r035");
    chk("r035_s0",   64'(samples[0 +: SW]), 64'd100);
    chk("r035_calc", 64'(calculate), 64'd1);
    chk("r035_fc",   64'(frame_count), 64'd1);

`ifdef DFT64_LOADER_DOUBLE_BUF_EN
    // Two frames back to back with done held off.
    do_reset();
    cyc(1'b0, '0, 1'b0, "idle");
    feed(2*NP, 1'b0, 1'b0, 0, "r037");
    chk("r037_ready", 64'(in_ready), 64'd0);
    repeat (20) cyc(1'b1, SW'($urandom), 1'b0, "r037_hold");
    cyc(1'b0, '0, 1'b1, "r037_done");
    chk("r037_calc", 64'(calculate), 64'd1);
    chk("r037_s0",   64'(samples[0 +: SW]), 64'd64);
    chk("r037_fc",   64'(frame_count), 64'd2);
    // done coinciding with the 64th accept of the next bank.
    cyc(1'b0, '0, 1'b0, "r029_pre");
    feed(NP-1, 1'b0, 1'b0, 500, "r029_fill");
    cyc(1'b1, SW'(563), 1'b1, "r029_hit");
    chk("r029_calc", 64'(calculate), 64'd1);
    chk("r029_s63",  64'(samples[63*SW +: SW]), 64'd563);
    chk("r029_fc",   64'(frame_count), 64'd3);
`endif

    // Random soak with sporadic done.
    repeat (1500)
      cyc(bit'($urandom_range(0, 1)), SW'($urandom), $urandom_range(0, 15) == 0, "soak");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
